instruction_sequencer: RTL and testbench

- Buffers a short program of 5-bit control words and plays it out to the control-unit decoder.
- Each control word has the format {load_weights, load_inputs, nn_start, activation[1:0]}.
- Each word is held for a programmed number of cycles. If the word sets nn_start, the sequencer then stalls until the datapath signals completion.
- Sits between the host/test interface and the control unit; it is the only driver of the instruction bus.

---
 rtl/instruction_sequencer.sv | 108 ++++++++++
 tb/tb_instruction_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: queues 5-bit control words and plays each out for its hold count,
// stalling on nn_start words until the datapath reports completion.
module instruction_sequencer #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_valid,
    input  logic [4:0]               prog_instr,
    input  logic [HOLD_W-1:0]        prog_hold,
    output logic                     prog_ready,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     nn_done,
    output logic [4:0]               instruction,
    output logic                     busy,
    output logic                     program_done,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISH} state_t;
    state_t state, nstate;
    logic [4:0] mem_instr [DEPTH];
    logic [HOLD_W-1:0] mem_hold [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0] word, nword, ninstr;
    logic [HOLD_W-1:0] hold_cnt, nhold, head_hold;
    logic push, pop, have;
    assign prog_ready = count != (AW+1)'(DEPTH);
    assign push = prog_valid && prog_ready && !abort;
    assign have = count != '0;
    assign head_hold = mem_hold[rd_ptr] == '0 ? HOLD_W'(1) : mem_hold[rd_ptr];
    always_comb begin
        nstate = state;
        nword = word;
        nhold = hold_cnt;
        ninstr = '0;
        pop = 1'b0;
        case (state)
            IDLE: if (start && have) begin
                pop = 1'b1;
                nstate = ISSUE;
            end
            ISSUE: if (hold_cnt > HOLD_W'(1)) begin
                nhold = hold_cnt - HOLD_W'(1);
                ninstr = word;
            end else if (word[2]) begin
                nstate = WAIT_DONE;
                ninstr = {3'b000, word[1:0]};
            end else if (have) pop = 1'b1;
            else nstate = FINISH;
            WAIT_DONE: if (!nn_done) ninstr = {3'b000, word[1:0]};
            else if (have) begin
                pop = 1'b1;
                nstate = ISSUE;
            end else nstate = FINISH;
            FINISH: nstate = IDLE;
            default: nstate = IDLE;
        endcase
        // a pop always loads the head word and drives it on the very next cycle
        if (pop) begin
            nword = mem_instr[rd_ptr];
            nhold = head_hold;
            ninstr = mem_instr[rd_ptr];
        end
        if (abort) begin
            nstate = IDLE;
            pop = 1'b0;
            ninstr = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            word <= '0;
            hold_cnt <= '0;
            instruction <= '0;
            busy <= 1'b0;
            program_done <= 1'b0;
        end else begin
            state <= nstate;
            word <= nword;
            hold_cnt <= nhold;
            instruction <= ninstr;
            busy <= nstate != IDLE;
            program_done <= nstate == FINISH;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                wr_ptr <= wr_ptr + AW'(push);
                rd_ptr <= rd_ptr + AW'(pop);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= prog_instr;
            mem_hold[wr_ptr] <= prog_hold;
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed and randomized programs checked against an expected
// output trace derived from the queued entries.
module tb_instruction_sequencer;
    localparam int DEPTH = 8;
    localparam int HOLD_W = 8;
    typedef struct packed {
        logic [4:0] w;
        logic [7:0] h;
    } ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1, prog_valid = 1'b0, start = 1'b0, abort = 1'b0, nn_done = 1'b0;
    logic [4:0] prog_instr = '0;
    logic [HOLD_W-1:0] prog_hold = '0;
    logic prog_ready, busy, program_done;
    logic [4:0] instruction;
    logic [3:0] count;
    int checks = 0, failures = 0, fixed_wait = 0;
    ent_t model_q[$];

    instruction_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .prog_valid(prog_valid), .prog_instr(prog_instr),
        .prog_hold(prog_hold), .prog_ready(prog_ready), .start(start), .abort(abort),
        .nn_done(nn_done), .instruction(instruction), .busy(busy),
        .program_done(program_done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] w, input logic [7:0] h);
        prog_valid = 1'b1;
        prog_instr = w;
        prog_hold = h;
        if (model_q.size() < DEPTH) model_q.push_back('{w: w, h: h});
        tick();
        prog_valid = 1'b0;
        chk("push_count", 32'(count), 32'(model_q.size()));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_instr"}, 32'(instruction), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(program_done), 0);
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_ready"}, 32'(prog_ready), 32'(model_q.size() != DEPTH));
    endtask

    // Expected trace: each word repeated max(hold,1) times, nn_start words followed by
    // their activation-only wait cycles, then one zero cycle carrying program_done.
    task automatic run_program(input string tag);
        int ei[$], ed[$], nd[$];
        int n, h, wt;
        n = model_q.size();
        foreach (model_q[j]) begin
            h = model_q[j].h == 0 ? 1 : int'(model_q[j].h);
            for (int i = 0; i < h; i++) begin
                ei.push_back(int'(model_q[j].w));
                ed.push_back(0);
                nd.push_back(int'($urandom_range(0, 3) == 0));
            end
            if (model_q[j].w[2]) begin
                wt = fixed_wait > 0 ? fixed_wait : int'($urandom_range(1, 4));
                for (int i = 0; i < wt; i++) begin
                    ei.push_back(int'(model_q[j].w[1:0]));
                    ed.push_back(0);
                    nd.push_back(int'(i == wt - 1));
                end
            end
        end
        ei.push_back(0);
        ed.push_back(1);
        nd.push_back(int'($urandom_range(0, 1)));
        model_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_count_after_pop"}, 32'(count), 32'(n - 1));
        chk({tag, "_ready_after_pop"}, 32'(prog_ready), 1);
        for (int k = 0; k < ei.size(); k++) begin
            chk($sformatf("%s_instr[%0d]", tag, k), 32'(instruction), 32'(ei[k]));
            chk($sformatf("%s_done[%0d]", tag, k), 32'(program_done), 32'(ed[k]));
            chk($sformatf("%s_busy[%0d]", tag, k), 32'(busy), 1);
            nn_done = nd[k][0];
            tick();
            nn_done = 1'b0;
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_idle("reset");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("start_empty");
        tick();
        check_idle("start_empty2");

        push(5'b01001, 8'd2);
        push(5'b10011, 8'd0);
        run_program("b2b");

        fixed_wait = 4;
        push(5'b00110, 8'd1);
        push(5'b01000, 8'd1);
        run_program("stall");
        fixed_wait = 0;

        for (int j = 0; j < DEPTH + 1; j++) push(5'(j) & 5'b11011, 8'd1);
        chk("full_ready", 32'(prog_ready), 0);
        chk("full_count", 32'(count), DEPTH);
        run_program("full");

        push(5'b00001, 8'd5);
        push(5'b00010, 8'd5);
        push(5'b00011, 8'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_pre_instr", 32'(instruction), 1);
        tick();
        abort = 1'b1;
        prog_valid = 1'b1;
        prog_instr = 5'b11111;
        prog_hold = 8'd1;
        tick();
        abort = 1'b0;
        prog_valid = 1'b0;
        model_q.delete();
        check_idle("abort");
        tick();
        check_idle("abort2");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("abort_start");

        push(5'b00110, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rstw_issue", 32'(instruction), 32'(5'b00110));
        tick();
        chk("rstw_wait", 32'(instruction), 32'(5'b00010));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_q.delete();
        check_idle("rst_wait");
        nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        check_idle("stale_done");
        tick();
        check_idle("stale_done2");

        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int j = 0; j < n; j++) push(5'($urandom), 8'($urandom_range(0, 3)));
            run_program($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
